// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared state encoding and control codes for the floating-point sequencer.
//   state_t   : FSM states of fp_control_unit
//   OP_ADD/OP_MUL, SMALL_SUB (small-ALU subtract), EXP_INC/EXP_DEC (exponent adjust codes)
package fp_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, EXP, ALIGN, ADD, MUL_CLR, MUL_RUN, NORM, ROUND, RENORM, DONE
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
  localparam logic [3:0] SMALL_SUB = 4'b0011;
  localparam logic [3:0] EXP_INC = 4'b0000;
  localparam logic [3:0] EXP_DEC = 4'b0001;
endpackage

// File: rtl/fp_control_unit.sv
// fp_control_unit: sequencer driving every control input of the floating_point datapath for one FADD/FMUL.
//   in : clk, reset (async active-low), start/op request, sign1/sign2, datapath status
//        (exp_diff, sum_carry, lead_zeros, round_ovf, mul_done)
//   out: busy, done, datapath mux selects, shifter/exponent/normalizer controls, big/small ALU controls
//   Optional FP_CTRL_ERR_EN: adds err, a 1-cycle pulse on start while busy or on a
//   multiply that leaves MUL_RUN by the cycle bound instead of mul_done.
module fp_control_unit
  import fp_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FP_CTRL_ERR_EN
  output logic        err,
`endif
  input  logic        start,
  input  logic        op,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [8:0]  exp_diff,
  input  logic        sum_carry,
  input  logic [4:0]  lead_zeros,
  input  logic        round_ovf,
  input  logic        mul_done,
  output logic        busy,
  output logic        done,
  output logic        controlToMux01,
  output logic        controlToMux02,
  output logic        controlToMux03,
  output logic        controlToMux04,
  output logic        controlToMux05,
  output logic [7:0]  controlShiftRight,
  output logic [3:0]  controlToIncreaseOrDecrease,
  output logic        IncreaseOrDecreaseEnable,
  output logic [7:0]  howManyToIncreaseOrDecrease,
  output logic        rightOrLeft,
  output logic [22:0] howMany,
  output logic        isSum,
  output logic        sum_sub,
  output logic        aluReset,
  output logic        muxDataRegValor2,
  output logic [3:0]  smallALUOperation,
  output logic        muxAControlSmall,
  output logic        muxBControlSmall,
  output logic        loadRegSmall
);
  localparam int CW = $clog2(MUL_CYCLES);
  state_t state, nextState;
  logic subReg;
  logic [CW-1:0] mulCnt;
  logic mulLast, expNeg, normInc, normDec;
  logic [8:0] absDiff;
  assign mulLast = mulCnt == CW'(MUL_CYCLES - 1);
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = start ? (op == OP_MUL ? MUL_CLR : EXP) : IDLE;
      EXP:     nextState = ALIGN;
      ALIGN:   nextState = ADD;
      ADD:     nextState = NORM;
      MUL_CLR: nextState = MUL_RUN;
      MUL_RUN: nextState = (mul_done || mulLast) ? NORM : MUL_RUN;
      NORM:    nextState = ROUND;
      ROUND:   nextState = round_ovf ? RENORM : DONE;
      RENORM:  nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mulCnt <= '0;
      subReg <= 1'b0;
    end else begin
      state  <= nextState;
      mulCnt <= (state == MUL_RUN && nextState == MUL_RUN) ? mulCnt + 1'b1 : '0;
      if (state == IDLE && start) subReg <= sign1 ^ sign2;
    end
  end
`ifdef FP_CTRL_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else err <= (start && state != IDLE) || (state == MUL_RUN && mulLast && !mul_done);
  end
`endif
  // exp_diff is two's complement; -256 has magnitude 256 which saturates to 255
  assign expNeg  = exp_diff[8];
  assign absDiff = expNeg ? -exp_diff : exp_diff;
  // RENORM reuses the carry path of NORM: shift right by one, exponent +1
  assign normInc = (state == NORM && sum_carry) || state == RENORM;
  assign normDec = state == NORM && !sum_carry && lead_zeros != 5'd0;
  assign busy                        = state != IDLE;
  assign done                        = state == DONE;
  assign loadRegSmall                = state == EXP;
  assign smallALUOperation           = busy ? SMALL_SUB : 4'b0000;
  assign muxAControlSmall            = 1'b0;
  assign muxBControlSmall            = 1'b0;
  assign controlToMux01              = (state == ALIGN && expNeg) || state == MUL_RUN;
  assign controlToMux03              = (state == ALIGN && !expNeg) || state == MUL_RUN;
  assign controlToMux04              = state == ALIGN && expNeg;
  assign controlToMux02              = state == RENORM;
  assign controlToMux05              = state == RENORM;
  assign controlShiftRight           = state == ALIGN ? (absDiff[8] ? 8'd255 : absDiff[7:0]) : 8'd0;
  assign isSum                       = state == ADD;
  assign sum_sub                     = state == ADD && subReg;
  assign aluReset                    = state == MUL_CLR;
  assign muxDataRegValor2            = state == MUL_RUN;
  assign rightOrLeft                 = normInc;
  assign IncreaseOrDecreaseEnable    = normInc || normDec;
  assign controlToIncreaseOrDecrease = normDec ? EXP_DEC : EXP_INC;
  assign howMany                     = normInc ? 23'd1 : normDec ? 23'(lead_zeros) : 23'd0;
  assign howManyToIncreaseOrDecrease = normInc ? 8'd1 : normDec ? 8'(lead_zeros) : 8'd0;
endmodule
